// File: rtl/memory_bus_if.sv
// ---------------------------------------------------------------------------
// memory_bus_if : CPU write-bus front end, one decoded strobe per write (rev 1.0)
// ---------------------------------------------------------------------------
`default_nettype none

module memory_bus_if #(
  parameter logic [1:0]  SEL_CONTROLLER          = 2'd0,
  parameter logic [1:0]  SEL_MOD                 = 2'd1,
  parameter logic [1:0]  SEL_DUTY_TABLE          = 2'd2,
  parameter logic [1:0]  SEL_STM                 = 2'd3,
  parameter logic [13:0] ADDR_MOD_MEM_WR_SEGMENT = 14'h0020,
  parameter logic [13:0] ADDR_STM_MEM_WR_SEGMENT = 14'h0021,
  parameter logic [13:0] ADDR_STM_MEM_WR_PAGE    = 14'h0022,
  parameter logic [13:0] ADDR_DUTY_TABLE_WR_PAGE = 14'h0023
) (
  input  logic        BUS_CLK,
  input  logic        RST,
  input  logic        EN,
  input  logic        WE,
  input  logic [1:0]  BRAM_SELECT,
  input  logic [13:0] BRAM_ADDR,
  input  logic [15:0] DATA_IN,
  output logic [15:0] WR_DATA,
  output logic        CTL_WE,
  output logic [13:0] CTL_ADDR,
  output logic        MOD_WE,
  output logic [14:0] MOD_ADDR,
  output logic        DUTY_WE,
  output logic [14:0] DUTY_ADDR,
  output logic        STM_WE,
  output logic [18:0] STM_ADDR
);

  logic        en_q,        en_d;
  logic        we_q,        we_d;
  logic [1:0]  sel_q,       sel_d;
  logic [13:0] addr_q,      addr_d;
  logic [15:0] data_q,      data_d;
  logic        we_dly_q,    we_dly_d;

  logic        ctl_we_q,    ctl_we_d;
  logic        mod_we_q,    mod_we_d;
  logic        duty_we_q,   duty_we_d;
  logic        stm_we_q,    stm_we_d;
  logic [15:0] wr_data_q,   wr_data_d;
  logic [13:0] ctl_addr_q,  ctl_addr_d;
  logic [14:0] mod_addr_q,  mod_addr_d;
  logic [14:0] duty_addr_q, duty_addr_d;
  logic [18:0] stm_addr_q,  stm_addr_d;

  logic        mod_seg_q,   mod_seg_d;
  logic        stm_seg_q,   stm_seg_d;
  logic [3:0]  stm_page_q,  stm_page_d;
  logic        duty_page_q, duty_page_d;

  logic        go;

  always_comb begin
    en_d        = EN;
    we_d        = WE;
    sel_d       = BRAM_SELECT;
    addr_d      = BRAM_ADDR;
    data_d      = DATA_IN;
    we_dly_d    = en_q & we_q;

    ctl_we_d    = 1'b0;
    mod_we_d    = 1'b0;
    duty_we_d   = 1'b0;
    stm_we_d    = 1'b0;
    wr_data_d   = wr_data_q;
    ctl_addr_d  = ctl_addr_q;
    mod_addr_d  = mod_addr_q;
    duty_addr_d = duty_addr_q;
    stm_addr_d  = stm_addr_q;

    mod_seg_d   = mod_seg_q;
    stm_seg_d   = stm_seg_q;
    stm_page_d  = stm_page_q;
    duty_page_d = duty_page_q;

    // Rising edge of the sampled EN&WE marks a new CPU write.
    go = en_q & we_q & ~we_dly_q;

    if (go) begin
      wr_data_d = data_q;
      case (sel_q)
        SEL_CONTROLLER: begin
          ctl_we_d   = 1'b1;
          ctl_addr_d = addr_q;
          if (addr_q == ADDR_MOD_MEM_WR_SEGMENT) mod_seg_d   = data_q[0];
          if (addr_q == ADDR_STM_MEM_WR_SEGMENT) stm_seg_d   = data_q[0];
          if (addr_q == ADDR_STM_MEM_WR_PAGE)    stm_page_d  = data_q[3:0];
          if (addr_q == ADDR_DUTY_TABLE_WR_PAGE) duty_page_d = data_q[0];
        end
        SEL_MOD: begin
          mod_we_d   = 1'b1;
          mod_addr_d = {mod_seg_q, addr_q};
        end
        SEL_DUTY_TABLE: begin
          duty_we_d   = 1'b1;
          duty_addr_d = {duty_page_q, addr_q};
        end
        SEL_STM: begin
          stm_we_d   = 1'b1;
          stm_addr_d = {stm_seg_q, stm_page_q, addr_q};
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge BUS_CLK) begin
    if (RST) begin
      en_q        <= 1'b0;
      we_q        <= 1'b0;
      sel_q       <= 2'd0;
      addr_q      <= 14'd0;
      data_q      <= 16'd0;
      we_dly_q    <= 1'b0;
      ctl_we_q    <= 1'b0;
      mod_we_q    <= 1'b0;
      duty_we_q   <= 1'b0;
      stm_we_q    <= 1'b0;
      wr_data_q   <= 16'd0;
      ctl_addr_q  <= 14'd0;
      mod_addr_q  <= 15'd0;
      duty_addr_q <= 15'd0;
      stm_addr_q  <= 19'd0;
      mod_seg_q   <= 1'b0;
      stm_seg_q   <= 1'b0;
      stm_page_q  <= 4'd0;
      duty_page_q <= 1'b0;
    end else begin
      en_q        <= en_d;
      we_q        <= we_d;
      sel_q       <= sel_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      we_dly_q    <= we_dly_d;
      ctl_we_q    <= ctl_we_d;
      mod_we_q    <= mod_we_d;
      duty_we_q   <= duty_we_d;
      stm_we_q    <= stm_we_d;
      wr_data_q   <= wr_data_d;
      ctl_addr_q  <= ctl_addr_d;
      mod_addr_q  <= mod_addr_d;
      duty_addr_q <= duty_addr_d;
      stm_addr_q  <= stm_addr_d;
      mod_seg_q   <= mod_seg_d;
      stm_seg_q   <= stm_seg_d;
      stm_page_q  <= stm_page_d;
      duty_page_q <= duty_page_d;
    end
  end

  assign WR_DATA   = wr_data_q;
  assign CTL_WE    = ctl_we_q;
  assign CTL_ADDR  = ctl_addr_q;
  assign MOD_WE    = mod_we_q;
  assign MOD_ADDR  = mod_addr_q;
  assign DUTY_WE   = duty_we_q;
  assign DUTY_ADDR = duty_addr_q;
  assign STM_WE    = stm_we_q;
  assign STM_ADDR  = stm_addr_q;

endmodule

`default_nettype wire

// File: tb/tb_memory_bus_if.sv
// ---------------------------------------------------------------------------
// tb_memory_bus_if : directed + random bench against a transaction-level model (rev 1.0)
// ---------------------------------------------------------------------------
`default_nettype none

module tb_memory_bus_if;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        we = 1'b0;
  logic [1:0]  sel = 2'd0;
  logic [13:0] addr = 14'd0;
  logic [15:0] din = 16'd0;

  logic [15:0] wr_data;
  logic        ctl_we, mod_we, duty_we, stm_we;
  logic [13:0] ctl_addr;
  logic [14:0] mod_addr, duty_addr;
  logic [18:0] stm_addr;

  always #5 clk = ~clk;

  memory_bus_if dut (
    .BUS_CLK    (clk),
    .RST        (rst),
    .EN         (en),
    .WE         (we),
    .BRAM_SELECT(sel),
    .BRAM_ADDR  (addr),
    .DATA_IN    (din),
    .WR_DATA    (wr_data),
    .CTL_WE     (ctl_we),
    .CTL_ADDR   (ctl_addr),
    .MOD_WE     (mod_we),
    .MOD_ADDR   (mod_addr),
    .DUTY_WE    (duty_we),
    .DUTY_ADDR  (duty_addr),
    .STM_WE     (stm_we),
    .STM_ADDR   (stm_addr)
  );

  int n_vec = 0;
  int n_err = 0;
  int n_ctl = 0, n_mod = 0, n_duty = 0, n_stm = 0;

  // Transaction-level reference: a write starts when the bus goes active,
  // and its strobe is emitted one edge later unless reset intervenes.
  logic        prev_act = 1'b0;
  logic        pend_v = 1'b0;
  logic [1:0]  pend_sel;
  logic [13:0] pend_addr;
  logic [15:0] pend_data;
  logic        m_mod_seg = 1'b0, m_stm_seg = 1'b0, m_duty_page = 1'b0;
  logic [3:0]  m_stm_page = 4'd0;
  logic [3:0]  exp_stb = 4'd0;
  logic [15:0] exp_wr_data = 16'd0;
  logic [13:0] exp_ctl = 14'd0;
  logic [14:0] exp_mod = 15'd0, exp_duty = 15'd0;
  logic [18:0] exp_stm = 19'd0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_edge();
    logic act;
    if (rst) begin
      prev_act = 1'b0; pend_v = 1'b0;
      m_mod_seg = 1'b0; m_stm_seg = 1'b0; m_duty_page = 1'b0; m_stm_page = 4'd0;
      exp_stb = 4'd0; exp_wr_data = 16'd0; exp_ctl = 14'd0;
      exp_mod = 15'd0; exp_duty = 15'd0; exp_stm = 19'd0;
    end else begin
      exp_stb = 4'd0;
      if (pend_v) begin
        exp_wr_data = pend_data;
        case (pend_sel)
          2'd0: begin
            exp_stb[3] = 1'b1;
            exp_ctl = pend_addr;
            if (pend_addr == 14'h20) m_mod_seg   = pend_data[0];
            if (pend_addr == 14'h21) m_stm_seg   = pend_data[0];
            if (pend_addr == 14'h22) m_stm_page  = pend_data[3:0];
            if (pend_addr == 14'h23) m_duty_page = pend_data[0];
          end
          2'd1: begin exp_stb[2] = 1'b1; exp_mod  = {m_mod_seg, pend_addr}; end
          2'd2: begin exp_stb[1] = 1'b1; exp_duty = {m_duty_page, pend_addr}; end
          default: begin
            exp_stb[0] = 1'b1;
            exp_stm = {m_stm_seg, m_stm_page, pend_addr};
          end
        endcase
      end
      act = en & we;
      pend_v = act & ~prev_act;
      pend_sel = sel; pend_addr = addr; pend_data = din;
      prev_act = act;
    end
  endtask

  task automatic step(input logic r, input logic e, input logic w, input logic [1:0] s,
                      input logic [13:0] a, input logic [15:0] d);
    rst = r; en = e; we = w; sel = s; addr = a; din = d;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    n_ctl += int'(ctl_we); n_mod += int'(mod_we); n_duty += int'(duty_we); n_stm += int'(stm_we);
    check("strobes", {28'd0, ctl_we, mod_we, duty_we, stm_we}, {28'd0, exp_stb});
    check("wr_data", {16'd0, wr_data}, {16'd0, exp_wr_data});
    check("ctl_addr", {18'd0, ctl_addr}, {18'd0, exp_ctl});
    check("mod_addr", {17'd0, mod_addr}, {17'd0, exp_mod});
    check("duty_addr", {17'd0, duty_addr}, {17'd0, exp_duty});
    check("stm_addr", {13'd0, stm_addr}, {13'd0, exp_stm});
  endtask

  task automatic wr(input logic [1:0] s, input logic [13:0] a, input logic [15:0] d, input int hold);
    for (int i = 0; i < hold; i++) step(1'b0, 1'b1, 1'b1, s, a, d);
    step(1'b0, 1'b1, 1'b0, s, a, d);
    step(1'b0, 1'b1, 1'b0, s, a, d);
  endtask

  int c_ctl, c_oth;

  initial begin
    @(negedge clk);
    step(1'b1, 1'b0, 1'b0, 2'd0, 14'd0, 16'd0);
    step(1'b1, 1'b0, 1'b0, 2'd0, 14'd0, 16'd0);

    // controller write, WE held two edges; strobe on the second edge
    c_ctl = n_ctl; c_oth = n_mod + n_duty + n_stm;
    step(1'b0, 1'b1, 1'b1, 2'd0, 14'h0105, 16'hBEEF);
    check("t1_no_early", {31'd0, ctl_we}, 32'd0);
    step(1'b0, 1'b1, 1'b1, 2'd0, 14'h0105, 16'hBEEF);
    check("t1_latency", {31'd0, ctl_we}, 32'd1);
    step(1'b0, 1'b1, 1'b0, 2'd0, 14'h0105, 16'hBEEF);
    check("t1_ctl_count", n_ctl - c_ctl, 1);
    check("t1_other", n_mod + n_duty + n_stm - c_oth, 0);
    check("t1_addr", {18'd0, ctl_addr}, 32'h0105);
    check("t1_data", {16'd0, wr_data}, 32'hBEEF);

    // mod segment then mod write
    c_ctl = n_ctl;
    wr(2'd0, 14'h0020, 16'h0001, 1);
    wr(2'd1, 14'h0003, 16'h1234, 1);
    check("t2_ctl_count", n_ctl - c_ctl, 1);
    check("t2_mod_addr", {17'd0, mod_addr}, 32'h4003);

    // STM segment/page
    wr(2'd0, 14'h0021, 16'hFFF1, 1);
    wr(2'd0, 14'h0022, 16'h0005, 1);
    wr(2'd3, 14'h0020, 16'hAAAA, 1);
    check("t3_stm_p5", {13'd0, stm_addr}, 32'h54020);
    wr(2'd0, 14'h0022, 16'h0006, 1);
    wr(2'd3, 14'h0020, 16'h5555, 1);
    check("t3_stm_p6", {13'd0, stm_addr}, 32'h58020);

    // duty page
    wr(2'd2, 14'h3FFF, 16'h0101, 1);
    check("t4_duty_p0", {17'd0, duty_addr}, 32'h3FFF);
    wr(2'd0, 14'h0023, 16'h0001, 1);
    wr(2'd2, 14'h3FFF, 16'h0202, 1);
    check("t4_duty_p1", {17'd0, duty_addr}, 32'h7FFF);

    // long hold, EN low, EN falling
    c_ctl = n_ctl;
    wr(2'd0, 14'h0010, 16'h0F0F, 10);
    check("t5_hold_one", n_ctl - c_ctl, 1);
    c_oth = n_ctl + n_mod + n_duty + n_stm;
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1, 2'd1, 14'h0001, 16'h1111);
    step(1'b0, 1'b0, 1'b0, 2'd1, 14'h0001, 16'h1111);
    step(1'b0, 1'b0, 1'b0, 2'd1, 14'h0001, 16'h1111);
    check("t5_en_low", n_ctl + n_mod + n_duty + n_stm - c_oth, 0);
    c_oth = n_duty;
    step(1'b0, 1'b1, 1'b1, 2'd2, 14'h0002, 16'h2222);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 2'd2, 14'h0002, 16'h2222);
    step(1'b0, 1'b0, 1'b0, 2'd2, 14'h0002, 16'h2222);
    check("t5_en_fall", n_duty - c_oth, 1);

    // reset on the edge where go is set
    c_oth = n_ctl + n_mod + n_duty + n_stm;
    step(1'b0, 1'b1, 1'b1, 2'd0, 14'h0021, 16'h0001);
    step(1'b1, 1'b0, 1'b0, 2'd0, 14'h0021, 16'h0001);
    step(1'b0, 1'b0, 1'b0, 2'd0, 14'h0000, 16'h0000);
    step(1'b0, 1'b0, 1'b0, 2'd0, 14'h0000, 16'h0000);
    check("t6_rst_drop", n_ctl + n_mod + n_duty + n_stm - c_oth, 0);
    wr(2'd1, 14'h0003, 16'h0001, 1);
    check("t6_mod_seg0", {17'd0, mod_addr}, 32'h0003);
    wr(2'd3, 14'h0001, 16'h0001, 1);
    check("t6_stm_zero", {13'd0, stm_addr}, 32'h00001);
    wr(2'd2, 14'h3FFF, 16'h0001, 1);
    check("t6_duty_pg0", {17'd0, duty_addr}, 32'h3FFF);

    // reset released while the write is still held
    c_ctl = n_ctl;
    step(1'b1, 1'b1, 1'b1, 2'd0, 14'h0050, 16'h0077);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1, 2'd0, 14'h0050, 16'h0077);
    step(1'b0, 1'b1, 1'b0, 2'd0, 14'h0050, 16'h0077);
    check("t6_release", n_ctl - c_ctl, 1);
    check("t6_rel_addr", {18'd0, ctl_addr}, 32'h0050);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      logic [13:0] a;
      logic [2:0]  pick;
      pick = 3'($urandom_range(0, 7));
      a = (pick < 3'd4) ? (14'h0020 + {12'd0, pick[1:0]}) : 14'($urandom);
      step(($urandom_range(0, 63) == 0), ($urandom_range(0, 7) != 0), ($urandom_range(0, 2) != 0),
           2'($urandom), a, 16'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/memory_bus_if.md
Name: memory_bus_if

Overview:
CPU-side write-bus front end. It samples the external memory bus (enable, write enable, 2-bit BRAM select, 14-bit address, 16-bit data) and emits exactly one single-cycle write strobe per CPU write transaction. The strobe is decoded to one of four targets: controller, modulation, duty table or STM. The block keeps shadow copies of the segment/page registers, so the mod, duty-table and STM write addresses are widened with those bits. It sits between the CPU pins and the BRAM blocks.

Parameters:
SEL_CONTROLLER, 2'd0, BRAM_SELECT code for the controller BRAM
SEL_MOD, 2'd1, BRAM_SELECT code for the modulation BRAM
SEL_DUTY_TABLE, 2'd2, BRAM_SELECT code for the duty-table BRAM
SEL_STM, 2'd3, BRAM_SELECT code for the STM BRAM
ADDR_MOD_MEM_WR_SEGMENT, 14'h0020, controller address of the mod write-segment register
ADDR_STM_MEM_WR_SEGMENT, 14'h0021, controller address of the STM write-segment register
ADDR_STM_MEM_WR_PAGE, 14'h0022, controller address of the STM write-page register
ADDR_DUTY_TABLE_WR_PAGE, 14'h0023, controller address of the duty-table write-page register

Ports:
BUS_CLK  in  1  bus clock; all logic on its rising edge
RST  in  1  synchronous, active-high reset
EN  in  1  chip enable (active high, already inverted from CPU_CN)
WE  in  1  write enable (active high)
BRAM_SELECT  in  2  target select
BRAM_ADDR  in  14  word address
DATA_IN  in  16  write data
WR_DATA  out  16  registered write data, common to all targets
CTL_WE  out  1  controller write strobe
CTL_ADDR  out  14  controller address
MOD_WE  out  1  mod write strobe
MOD_ADDR  out  15  {mod_segment, addr}
DUTY_WE  out  1  duty-table write strobe
DUTY_ADDR  out  15  {duty_page, addr}
STM_WE  out  1  STM write strobe
STM_ADDR  out  19  {stm_segment, stm_page[3:0], addr}

Behaviour:
- Input stage: EN, WE, BRAM_SELECT, BRAM_ADDR and DATA_IN are registered every edge (stage s1). A second register holds the previous s1 value of WE&EN (we_d).
- Write detect: go = s1.EN & s1.WE & ~we_d. This is a rising-edge detect, so WE held high for any number of cycles yields exactly one strobe.
- Output stage, on the edge after go:
  - exactly one of CTL_WE/MOD_WE/DUTY_WE/STM_WE goes high for one cycle, chosen by s1.BRAM_SELECT;
  - WR_DATA and the address outputs are loaded from s1 in the same edge;
  - total latency from the first edge sampling EN=WE=1 to the strobe is 2 edges.
- Address and data outputs hold their last values when no strobe is active. Strobes are 0 whenever go was 0.
- Shadow registers update when go is set, select = SEL_CONTROLLER and the address matches:
  - mod_segment <= DATA_IN[0] at ADDR_MOD_MEM_WR_SEGMENT;
  - stm_segment <= DATA_IN[0] at ADDR_STM_MEM_WR_SEGMENT;
  - stm_page <= DATA_IN[3:0] at ADDR_STM_MEM_WR_PAGE;
  - duty_page <= DATA_IN[0] at ADDR_DUTY_TABLE_WR_PAGE.
- Shadow updates happen on the same edge as the CTL_WE output load; CTL_WE still fires, so the write is forwarded to the controller BRAM.
- A new shadow value affects only later transactions, never the strobe it arrives in.
- Address widening: MOD_ADDR = {mod_segment, addr}; DUTY_ADDR = {duty_page, addr}; STM_ADDR = {stm_segment, stm_page, addr}. Upper data bits of shadow writes are ignored.
- WE high with EN low: no strobe. EN falling while WE is high: no further strobe. WE must fall and rise again for the next write.
- Reset: clears all registers on the next edge.
  - All strobes, WR_DATA, all addresses, we_d and all shadow registers go to 0.
  - A write whose go was computed before reset is discarded; its strobe must not appear after RST.
  - When RST deasserts while WE&EN is still high, we_d is 0, so the held write produces one strobe.

Test Plan:
- Reset then a controller write (sel 0, addr 0x0105, data 0xBEEF, WE high for 2 edges) -> exactly one CTL_WE pulse, CTL_ADDR=0x0105, WR_DATA=0xBEEF, 2 edges after first sampled WE; other strobes stay 0.
- Write 1 to ADDR_MOD_MEM_WR_SEGMENT, then a mod write (addr 0x0003, data 0x1234) -> CTL_WE once, then MOD_WE once with MOD_ADDR=0x4003.
- STM segment=1, page=5, then an STM write (addr 0x0020) -> STM_ADDR = {1, 4'h5, 14'h0020}; then page=6 and the same addr -> page field is 6.
- Duty page=1, then a duty write at addr 0x3FFF -> DUTY_ADDR=0x7FFF; a duty write before the page write -> 0x3FFF.
- WE held high for 10 edges -> one strobe only; WE high with EN=0 -> no strobe.
- RST asserted on the edge where go is set -> no strobe and shadow registers are 0 afterwards; RST released with WE&EN still high -> one strobe.
